// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared encodings and shadow-entry layout for the hazard controller
package core_pkg;

  // EX operand source selects; values above FWD_WB name deeper forwarding stages
  localparam int FWD_SEL_W   = 3;
  localparam logic [FWD_SEL_W-1:0] FWD_REGFILE = 3'd0;
  localparam logic [FWD_SEL_W-1:0] FWD_MEM     = 3'd1;
  localparam logic [FWD_SEL_W-1:0] FWD_WB      = 3'd2;

  // Bit positions within the flush vector
  localparam int FLUSH_IFID  = 0;
  localparam int FLUSH_IDEX  = 1;
  localparam int FLUSH_EXMEM = 2;

  // Shadow-entry control field widths
  localparam int SH_VALID_W = 1;
  localparam int SH_CTRL_W  = 2;

  // Control part of a shadow entry; the destination register is kept alongside
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
  } sh_ctrl_t;

endpackage

// File: rtl/hz_fwd_sel.sv
// rtl/hz_fwd_sel.sv - priority matcher picking the youngest forwarding stage for one operand
module hz_fwd_sel
  import core_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2
) (
  input  logic [REG_AW-1:0]            src_i,
  input  logic                         use_i,
  input  logic                         ex_valid_i,
  input  logic [FWD_STAGES-1:0]        valid_i,
  input  logic [FWD_STAGES-1:0]        regwrite_i,
  input  logic                         mem_load_i,
  input  logic [FWD_STAGES*REG_AW-1:0] rd_i,
  output logic [FWD_SEL_W-1:0]         sel_o
);

  // Scan oldest to youngest so the lowest matching stage wins; a load in MEM has no data yet
  always_comb begin
    sel_o = FWD_REGFILE;
    if (ex_valid_i && use_i && (src_i != '0)) begin
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (valid_i[k-1] && regwrite_i[k-1] &&
            (rd_i[(k-1)*REG_AW +: REG_AW] == src_i) &&
            !((k == 1) && mem_load_i)) begin
          sel_o = FWD_SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - shadow-pipeline hazard, flush and forwarding controller
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int FWD_STAGES  = 2,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   redirect,
  input  logic                   mc_busy,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   idex_write,
  output logic                   id_bubble,
  output logic [FLUSH_DEPTH-1:0] flush,
  output logic [FWD_SEL_W-1:0]   fwd_a,
  output logic [FWD_SEL_W-1:0]   fwd_b,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  // Entry 0 mirrors ID/EX, entry k mirrors the k-th register after EX
  sh_ctrl_t          ctl_q [FWD_STAGES+1];
  sh_ctrl_t          ctl_d [FWD_STAGES+1];
  logic [REG_AW-1:0] rd_q  [FWD_STAGES+1];
  logic [REG_AW-1:0] rd_d  [FWD_STAGES+1];
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d;
  logic              urs_q, urs_d, urt_q, urt_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

  logic load_use, do_flush, stall_mc, stall_lu;
  logic [FWD_STAGES-1:0]        fv, frw;
  logic [FWD_STAGES*REG_AW-1:0] frd;
  logic [FWD_SEL_W-1:0]         sel_a, sel_b;

  // Hazard classification with reset > redirect > mc_busy > load-use priority
  always_comb begin
    load_use = ctl_q[0].valid && ctl_q[0].memread && (rd_q[0] != '0) &&
               ((id_uses_rs && (rd_q[0] == id_rs)) ||
                (id_uses_rt && (rd_q[0] == id_rt)));
    do_flush = !reset && redirect;
    stall_mc = !reset && !redirect && mc_busy;
    stall_lu = !reset && !redirect && !mc_busy && load_use;
  end

  assign pc_write   = !(stall_mc || stall_lu);
  assign ifid_write = !(stall_mc || stall_lu);
  assign idex_write = !stall_mc;
  assign id_bubble  = stall_lu;
  assign flush      = do_flush ? {FLUSH_DEPTH{1'b1}} : '0;
  assign fwd_a      = reset ? FWD_REGFILE : sel_a;
  assign fwd_b      = reset ? FWD_REGFILE : sel_b;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

  // Next shadow state: shift by default, then apply squash, hold or bubble
  always_comb begin
    ctl_d[0] = '{valid: id_valid, regwrite: id_regwrite, memread: id_memread};
    rd_d[0]  = id_rd;
    rs_d     = id_rs;
    rt_d     = id_rt;
    urs_d    = id_uses_rs;
    urt_d    = id_uses_rt;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      ctl_d[k] = ctl_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
    if (do_flush) begin
      // Only stages actually squashed lose their entry; the MEM entry moves on
      if (FLUSH_DEPTH > FLUSH_IDEX) begin
        ctl_d[0] = '0;
        urs_d    = 1'b0;
        urt_d    = 1'b0;
      end
      if (FLUSH_DEPTH > FLUSH_EXMEM) begin
        ctl_d[1] = '0;
      end
    end else if (stall_mc) begin
      ctl_d[0] = ctl_q[0];
      rd_d[0]  = rd_q[0];
      rs_d     = rs_q;
      rt_d     = rt_q;
      urs_d    = urs_q;
      urt_d    = urt_q;
      ctl_d[1] = '0;
    end else if (stall_lu) begin
      ctl_d[0] = '0;
      urs_d    = 1'b0;
      urt_d    = 1'b0;
    end
  end

  // Shadow registers and saturating counters
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= FWD_STAGES; k++) begin
        ctl_q[k] <= '0;
        rd_q[k]  <= '0;
      end
      rs_q        <= '0;
      rt_q        <= '0;
      urs_q       <= 1'b0;
      urt_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 0; k <= FWD_STAGES; k++) begin
        ctl_q[k] <= ctl_d[k];
        rd_q[k]  <= rd_d[k];
      end
      rs_q  <= rs_d;
      rt_q  <= rt_d;
      urs_q <= urs_d;
      urt_q <= urt_d;
      if ((stall_mc || stall_lu) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (do_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Flatten the post-EX entries for the operand matchers
  always_comb begin
    fv  = '0;
    frw = '0;
    frd = '0;
    for (int k = 1; k <= FWD_STAGES; k++) begin
      fv[k-1]                     = ctl_q[k].valid;
      frw[k-1]                    = ctl_q[k].regwrite;
      frd[(k-1)*REG_AW +: REG_AW] = rd_q[k];
    end
  end

  hz_fwd_sel #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES)) u_sel_a (
    .src_i      (rs_q),
    .use_i      (urs_q),
    .ex_valid_i (ctl_q[0].valid),
    .valid_i    (fv),
    .regwrite_i (frw),
    .mem_load_i (ctl_q[1].memread),
    .rd_i       (frd),
    .sel_o      (sel_a)
  );

  hz_fwd_sel #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES)) u_sel_b (
    .src_i      (rt_q),
    .use_i      (urt_q),
    .ex_valid_i (ctl_q[0].valid),
    .valid_i    (fv),
    .regwrite_i (frw),
    .mem_load_i (ctl_q[1].memread),
    .rd_i       (frd),
    .sel_o      (sel_b)
  );

endmodule
